// File: rtl/vfp_config_sequencer.sv
// vfp_config_sequencer
//   Walks a table of NUM_ENTRIES {address, data} pairs and writes each one out
//   over an AXI4-Lite master port. When verify_en is set at start, each entry
//   is read back after its write and compared against the written data. The
//   first bad response, mismatch or handshake timeout aborts the run and
//   latches the failing entry index.
//
// Ports
//   vfpconfig_aclk, vfpconfig_aresetn : clock, async active-low reset
//   start, verify_en                  : run request, read-back enable
//   busy, done, error, err_index      : run status (done is a 1-cycle pulse)
//   tbl_index / tbl_addr, tbl_data    : table select and returned entry
//   vfpconfig_aw*/w*/b*/ar*/r*        : AXI4-Lite master channels
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | capture table entry into address/data registers
// WRITE | AW and W channels outstanding
// WRESP | waiting for write response
// READ  | AR channel outstanding (verify only)
// RDATA | waiting for read data (verify only)
// NEXT  | advance to next entry or finish
// DONE  | success, done pulse
// FAIL  | abort, done pulse with error latched
module vfp_config_sequencer #(
  parameter int C_vfpConfig_DATA_WIDTH = 32,
  parameter int C_vfpConfig_ADDR_WIDTH = 8,
  parameter int NUM_ENTRIES            = 16,
  parameter int TIMEOUT_CYCLES         = 255
) (
  input  logic                                  vfpconfig_aclk,
  input  logic                                  vfpconfig_aresetn,
  input  logic                                  start,
  input  logic                                  verify_en,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error,
  output logic [7:0]                            err_index,
  output logic [7:0]                            tbl_index,
  input  logic [C_vfpConfig_ADDR_WIDTH-1:0]     tbl_addr,
  input  logic [C_vfpConfig_DATA_WIDTH-1:0]     tbl_data,
  output logic [C_vfpConfig_ADDR_WIDTH-1:0]     vfpconfig_awaddr,
  output logic [2:0]                            vfpconfig_awprot,
  output logic                                  vfpconfig_awvalid,
  input  logic                                  vfpconfig_awready,
  output logic [C_vfpConfig_DATA_WIDTH-1:0]     vfpconfig_wdata,
  output logic [C_vfpConfig_DATA_WIDTH/8-1:0]   vfpconfig_wstrb,
  output logic                                  vfpconfig_wvalid,
  input  logic                                  vfpconfig_wready,
  input  logic [1:0]                            vfpconfig_bresp,
  input  logic                                  vfpconfig_bvalid,
  output logic                                  vfpconfig_bready,
  output logic [C_vfpConfig_ADDR_WIDTH-1:0]     vfpconfig_araddr,
  output logic [2:0]                            vfpconfig_arprot,
  output logic                                  vfpconfig_arvalid,
  input  logic                                  vfpconfig_arready,
  input  logic [C_vfpConfig_DATA_WIDTH-1:0]     vfpconfig_rdata,
  input  logic [1:0]                            vfpconfig_rresp,
  input  logic                                  vfpconfig_rvalid,
  output logic                                  vfpconfig_rready
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    LAST_IDX = 8'(NUM_ENTRIES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WRITE, S_WRESP, S_READ, S_RDATA, S_NEXT, S_DONE, S_FAIL
  } state_t;

  state_t          state;
  logic [TW-1:0]   wait_cnt;
  logic            verify_q;
  logic            aw_done;
  logic            w_done;
  logic            aw_ok;
  logic            w_ok;
  logic            tmo;
  logic            fail_now;

  assign vfpconfig_awprot = 3'b000;
  assign vfpconfig_arprot = 3'b000;
  assign vfpconfig_wstrb  = '1;

  // A channel counts as accepted if it already handshook or does so this cycle.
  assign aw_ok = aw_done | (vfpconfig_awvalid & vfpconfig_awready);
  assign w_ok  = w_done  | (vfpconfig_wvalid  & vfpconfig_wready);
  // Down-counter loaded on entry to each wait state; zero is the last allowed cycle.
  assign tmo   = (wait_cnt == '0);

  always_comb begin
    fail_now = 1'b0;
    case (state)
      S_WRITE: fail_now = !(aw_ok && w_ok) && tmo;
      S_WRESP: fail_now = vfpconfig_bvalid ? (vfpconfig_bresp != 2'b00) : tmo;
      S_READ:  fail_now = !vfpconfig_arready && tmo;
      S_RDATA: fail_now = vfpconfig_rvalid ?
                          ((vfpconfig_rresp != 2'b00) || (vfpconfig_rdata != vfpconfig_wdata)) : tmo;
      default: fail_now = 1'b0;
    endcase
  end

  always_ff @(posedge vfpconfig_aclk or negedge vfpconfig_aresetn) begin
    if (!vfpconfig_aresetn) begin
      state             <= S_IDLE;
      wait_cnt          <= '0;
      verify_q          <= 1'b0;
      aw_done           <= 1'b0;
      w_done            <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      err_index         <= 8'd0;
      tbl_index         <= 8'd0;
      vfpconfig_awaddr  <= '0;
      vfpconfig_araddr  <= '0;
      vfpconfig_wdata   <= '0;
      vfpconfig_awvalid <= 1'b0;
      vfpconfig_wvalid  <= 1'b0;
      vfpconfig_bready  <= 1'b0;
      vfpconfig_arvalid <= 1'b0;
      vfpconfig_rready  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wait_cnt != '0) wait_cnt <= wait_cnt - TW'(1);

      case (state)
        S_IDLE: begin
          if (start) begin
            error     <= 1'b0;
            err_index <= 8'd0;
            tbl_index <= 8'd0;
            verify_q  <= verify_en;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          vfpconfig_awaddr  <= tbl_addr;
          vfpconfig_araddr  <= tbl_addr;
          vfpconfig_wdata   <= tbl_data;
          vfpconfig_awvalid <= 1'b1;
          vfpconfig_wvalid  <= 1'b1;
          aw_done           <= 1'b0;
          w_done            <= 1'b0;
          wait_cnt          <= TO_LOAD;
          state             <= S_WRITE;
        end
        S_WRITE: begin
          if (aw_ok && w_ok) begin
            vfpconfig_awvalid <= 1'b0;
            vfpconfig_wvalid  <= 1'b0;
            vfpconfig_bready  <= 1'b1;
            wait_cnt          <= TO_LOAD;
            state             <= S_WRESP;
          end else begin
            if (vfpconfig_awvalid && vfpconfig_awready) begin
              vfpconfig_awvalid <= 1'b0;
              aw_done           <= 1'b1;
            end
            if (vfpconfig_wvalid && vfpconfig_wready) begin
              vfpconfig_wvalid <= 1'b0;
              w_done           <= 1'b1;
            end
          end
        end
        S_WRESP: begin
          if (vfpconfig_bvalid) begin
            vfpconfig_bready <= 1'b0;
            if (verify_q) begin
              vfpconfig_arvalid <= 1'b1;
              wait_cnt          <= TO_LOAD;
              state             <= S_READ;
            end else begin
              state <= S_NEXT;
            end
          end
        end
        S_READ: begin
          if (vfpconfig_arready) begin
            vfpconfig_arvalid <= 1'b0;
            vfpconfig_rready  <= 1'b1;
            wait_cnt          <= TO_LOAD;
            state             <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (vfpconfig_rvalid) begin
            vfpconfig_rready <= 1'b0;
            state            <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (tbl_index == LAST_IDX) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            tbl_index <= tbl_index + 8'd1;
            state     <= S_LOAD;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_FAIL: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Any abort condition overrides the per-state update above.
      if (fail_now) begin
        vfpconfig_awvalid <= 1'b0;
        vfpconfig_wvalid  <= 1'b0;
        vfpconfig_bready  <= 1'b0;
        vfpconfig_arvalid <= 1'b0;
        vfpconfig_rready  <= 1'b0;
        error             <= 1'b1;
        err_index         <= tbl_index;
        done              <= 1'b1;
        state             <= S_FAIL;
      end
    end
  end

endmodule

// File: tb/tb_vfp_config_sequencer.sv
module tb_vfp_config_sequencer;
  localparam int DW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic start = 1'b0;
  logic verify_en = 1'b0;
  logic busy, done, error;
  logic [7:0] err_index, tbl_index;
  logic [AW-1:0] tbl_addr, awaddr, araddr;
  logic [DW-1:0] tbl_data, wdata, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;

  always #5 clk = ~clk;

  // Table contents seen by the DUT.
  assign tbl_addr = 8'h10 + {tbl_index[5:0], 2'b00};
  assign tbl_data = {16'hC0DE, tbl_index, tbl_index};

  vfp_config_sequencer #(
    .C_vfpConfig_DATA_WIDTH(DW), .C_vfpConfig_ADDR_WIDTH(AW),
    .NUM_ENTRIES(4), .TIMEOUT_CYCLES(255)
  ) dut (
    .vfpconfig_aclk(clk), .vfpconfig_aresetn(aresetn),
    .start(start), .verify_en(verify_en),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .tbl_index(tbl_index), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .vfpconfig_awaddr(awaddr), .vfpconfig_awprot(awprot),
    .vfpconfig_awvalid(awvalid), .vfpconfig_awready(awready),
    .vfpconfig_wdata(wdata), .vfpconfig_wstrb(wstrb),
    .vfpconfig_wvalid(wvalid), .vfpconfig_wready(wready),
    .vfpconfig_bresp(bresp), .vfpconfig_bvalid(bvalid), .vfpconfig_bready(bready),
    .vfpconfig_araddr(araddr), .vfpconfig_arprot(arprot),
    .vfpconfig_arvalid(arvalid), .vfpconfig_arready(arready),
    .vfpconfig_rdata(rdata), .vfpconfig_rresp(rresp),
    .vfpconfig_rvalid(rvalid), .vfpconfig_rready(rready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Scoreboard queues
  logic [7:0]  exp_aw_q[$];
  logic [31:0] exp_w_q[$];
  logic [7:0]  exp_ar_q[$];
  logic [8:0]  exp_res_q[$];   // {error, err_index}

  logic [7:0]  addr_tab [4] = '{8'h10, 8'h14, 8'h18, 8'h1C};
  logic [31:0] data_tab [4] = '{32'hC0DE0000, 32'hC0DE0101, 32'hC0DE0202, 32'hC0DE0303};

  task automatic push_writes(input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) begin
      exp_aw_q.push_back(addr_tab[i]);
      exp_w_q.push_back(data_tab[i]);
    end
  endtask

  task automatic push_reads(input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) exp_ar_q.push_back(addr_tab[i]);
  endtask

  // Slave configuration (written by the main sequence only)
  int cfg_aw_delay = 0;
  int cfg_w_delay  = 0;      // extra wready wait for entry 0
  int cfg_bresp_err = -1;    // entry answered with SLVERR
  int cfg_rx_idx   = -1;     // entry whose read data is corrupted
  bit cfg_w_stall  = 0;
  bit cfg_b_hold   = 0;

  // AXI4-Lite slave model: drives at negedge+1, stable across the next posedge.
  initial begin
    int aw_wait, w_wait, aw_cnt, w_cnt, b_cnt, r_cnt;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, r_pend;
    logic [31:0] hs_wdata, last_wdata;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    aw_wait = 0; w_wait = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; r_pend = 0;
    hs_wdata = 0; last_wdata = 0;
    forever begin
      @(negedge clk); #1;
      if (!aresetn || start) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_wait = 0; w_wait = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; r_pend = 0;
      end else begin
        if (aw_hs) aw_cnt++;
        if (w_hs) begin last_wdata = hs_wdata; w_cnt++; end
        if (b_hs) begin bvalid = 0; b_cnt++; end
        if (ar_hs) r_pend = 1;
        if (r_hs) begin r_pend = 0; rvalid = 0; r_cnt++; end
        awready = awvalid && (aw_wait >= cfg_aw_delay);
        wready  = wvalid && !cfg_w_stall && (w_wait >= ((w_cnt == 0) ? cfg_w_delay : 0));
        aw_wait = awvalid ? aw_wait + 1 : 0;
        w_wait  = wvalid ? w_wait + 1 : 0;
        if (!bvalid && !cfg_b_hold && aw_cnt > b_cnt && w_cnt > b_cnt) begin
          bvalid = 1;
          bresp  = (b_cnt == cfg_bresp_err) ? 2'b10 : 2'b00;
        end
        arready = arvalid;
        if (r_pend) begin
          rvalid = 1;
          rresp  = 2'b00;
          rdata  = last_wdata ^ ((r_cnt == cfg_rx_idx) ? 32'h1 : 32'h0);
        end
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        if (w_hs) hs_wdata = wdata;
        b_hs  = bvalid && bready;
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
      end
    end
  end

  // Monitor: samples at negedge+2, i.e. exactly what the next posedge sees.
  initial begin
    bit p_aw, p_w;
    logic [7:0] p_awaddr;
    logic [31:0] p_wdata;
    p_aw = 0; p_w = 0; p_awaddr = 0; p_wdata = 0;
    forever begin
      @(negedge clk); #2;
      if (!aresetn) begin
        p_aw = 0; p_w = 0;
        continue;
      end
      if (p_aw && awvalid) check("awaddr_stable", awaddr, p_awaddr);
      if (p_w && wvalid)   check("wdata_stable", wdata, p_wdata);
      if (awvalid && awready) begin
        check("aw_expected", exp_aw_q.size() != 0, 1);
        if (exp_aw_q.size() != 0) check("aw_addr", awaddr, exp_aw_q.pop_front());
        check("awprot", awprot, 3'b000);
      end
      if (wvalid && wready) begin
        check("w_expected", exp_w_q.size() != 0, 1);
        if (exp_w_q.size() != 0) check("w_data", wdata, exp_w_q.pop_front());
        check("wstrb", wstrb, 4'hF);
      end
      if (arvalid && arready) begin
        check("ar_expected", exp_ar_q.size() != 0, 1);
        if (exp_ar_q.size() != 0) check("ar_addr", araddr, exp_ar_q.pop_front());
      end
      if (done) begin
        check("done_expected", exp_res_q.size() != 0, 1);
        if (exp_res_q.size() != 0) check("done_result", {error, err_index}, exp_res_q.pop_front());
      end
      p_aw = awvalid && !awready; p_awaddr = awaddr;
      p_w  = wvalid && !wready;   p_wdata  = wdata;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, {busy, done, error, awvalid, wvalid, bready, arvalid, rready}, 8'h00);
    check({tag, "_idx"}, {err_index, tbl_index}, 16'h0000);
    check({tag, "_addr"}, {awaddr, araddr}, 16'h0000);
    check({tag, "_wdata"}, wdata, 32'h0);
  endtask

  task automatic run_seq(input bit ven, output int lat, output int aw_hi, output int w_hi,
                         output int b_hi, output int err_first, output logic [4:0] v_done);
    lat = -1; aw_hi = 0; w_hi = 0; b_hi = 0; v_done = 5'h1F;
    @(negedge clk); verify_en = ven; start = 1;
    @(negedge clk); start = 0; verify_en = 0;
    err_first = error;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      aw_hi += int'(awvalid); w_hi += int'(wvalid); b_hi += int'(bready);
      if (done) begin
        lat = n;
        v_done = {awvalid, wvalid, bready, arvalid, rready};
        break;
      end
    end
  endtask

  task automatic post_done(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_busy_drop"}, busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, awh, wh, bh, e0;
    logic [4:0] vd;
    bit seen;

    #3;
    check_reset_vals("por");
    repeat (3) @(negedge clk);
    aresetn = 1;
    repeat (5) @(negedge clk);
    check("idle_after_reset", {busy, awvalid, wvalid, arvalid}, 4'h0);

    // Plain 4-entry run, zero-wait slave
    push_writes(0, 4); exp_res_q.push_back(9'h000);
    run_seq(0, lat, awh, wh, bh, e0, vd);
    check("t1_latency", lat, 16);
    check("t1_aw_cycles", awh, 4);
    check("t1_b_cycles", bh, 4);
    post_done("t1");

    // Verified run, all reads match
    push_writes(0, 4); push_reads(0, 4); exp_res_q.push_back(9'h000);
    run_seq(1, lat, awh, wh, bh, e0, vd);
    check("t2_latency", lat, 24);
    post_done("t2");

    // awready three cycles ahead of wready on entry 0
    cfg_w_delay = 3;
    push_writes(0, 4); exp_res_q.push_back(9'h000);
    run_seq(0, lat, awh, wh, bh, e0, vd);
    check("t3_latency", lat, 19);
    check("t3_aw_cycles", awh, 4);
    check("t3_w_cycles", wh, 7);
    check("t3_b_cycles", bh, 4);
    post_done("t3");
    cfg_w_delay = 0;

    // SLVERR on entry 2
    cfg_bresp_err = 2;
    push_writes(0, 3); exp_res_q.push_back(9'h102);
    run_seq(0, lat, awh, wh, bh, e0, vd);
    check("t4_latency", lat, 11);
    post_done("t4");
    repeat (10) @(negedge clk);
    check("t4_error_sticky", {error, err_index}, 9'h102);
    cfg_bresp_err = -1;

    // Read-back mismatch on entry 1
    cfg_rx_idx = 1;
    push_writes(0, 2); push_reads(0, 2); exp_res_q.push_back(9'h101);
    run_seq(1, lat, awh, wh, bh, e0, vd);
    check("t5_error_cleared_at_start", e0, 0);
    check("t5_latency", lat, 11);
    post_done("t5");
    cfg_rx_idx = -1;

    // wready never arrives: WRITE timeout
    cfg_w_stall = 1;
    exp_aw_q.push_back(addr_tab[0]); exp_res_q.push_back(9'h100);
    run_seq(0, lat, awh, wh, bh, e0, vd);
    check("t6_latency", lat, 256);
    check("t6_w_cycles", wh, 255);
    check("t6_aw_cycles", awh, 1);
    check("t6_valids_at_fail", vd, 5'h00);
    post_done("t6");
    cfg_w_stall = 0;

    // Reset asserted while waiting in WRESP
    cfg_b_hold = 1;
    push_writes(0, 1);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      if (bready) begin seen = 1; break; end
      @(negedge clk);
    end
    check("t7_reached_wresp", seen, 1'b1);
    #3 aresetn = 0;
    #1 check_reset_vals("t7_rst");
    repeat (2) @(negedge clk);
    aresetn = 1;
    cfg_b_hold = 0;
    @(negedge clk);
    push_writes(0, 4); exp_res_q.push_back(9'h000);
    run_seq(0, lat, awh, wh, bh, e0, vd);
    check("t7_restart_latency", lat, 16);
    post_done("t7");

    repeat (5) @(negedge clk);
    check("q_aw_empty", exp_aw_q.size(), 0);
    check("q_w_empty", exp_w_q.size(), 0);
    check("q_ar_empty", exp_ar_q.size(), 0);
    check("q_res_empty", exp_res_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
